// File: rtl/alu_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_sched
//  Description : Round-robin scheduler that time-shares one combinational
//                floating-point ALU between NREQ requesters. Captures the
//                winner's operands, waits a settle window, samples the ALU
//                result, returns it to the owner and keeps sticky flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_req_sched #(
   parameter int EXP    = 8,
   parameter int FRAC   = 23,
   parameter int WIDTH  = EXP + FRAC + 1,
   parameter int NREQ   = 2,
   parameter int SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_op_a,
   input  logic [NREQ*WIDTH-1:0]   req_op_b,
   input  logic [NREQ*2-1:0]       req_op_code,
   input  logic [NREQ-1:0]         req_rnd,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [WIDTH-1:0]        rsp_result,
   output logic [4:0]              rsp_flags,
   output logic [WIDTH-1:0]        alu_op_a,
   output logic [WIDTH-1:0]        alu_op_b,
   output logic [1:0]              alu_op_code,
   output logic                    alu_rnd,
   input  logic [WIDTH-1:0]        alu_result,
   input  logic [4:0]              alu_flags,
   output logic [4:0]              sticky_flags,
   input  logic                    sticky_clr,
   output logic                    busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0]    S_IDLE   = 2'd0;
   localparam logic [1:0]    S_EXEC   = 2'd1;
   localparam logic [1:0]    S_RESP   = 2'd2;

   localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
   localparam logic [PW:0]   NREQ_EXT = (PW + 1)'(NREQ);
   localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    owner;
   logic [CW-1:0]    cnt;

   logic [NREQ-1:0]  valid_rot;
   logic [PW-1:0]    offset;
   logic [PW:0]      grant_sum;
   logic [PW-1:0]    grant_idx;
   logic             grant_found;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [1:0]       sel_op;
   logic             sel_rnd;
   logic             capture;

   assign capture = (state == S_EXEC) && (cnt == '0);

   // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest
   // set bit, then map the offset back to an absolute requester index.
   always_comb begin
      valid_rot   = (req_valid >> rr_ptr) | (req_valid << (NREQ_EXT - {1'b0, rr_ptr}));
      grant_found = 1'b0;
      offset      = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (valid_rot[j]) begin
            grant_found = 1'b1;
            offset      = PW'(j);
         end
      end
      grant_sum = {1'b0, rr_ptr} + {1'b0, offset};
      if (grant_sum > {1'b0, LAST_REQ}) begin
         grant_sum = grant_sum - NREQ_EXT;
      end
      grant_idx = grant_sum[PW-1:0];
   end

   // Operand mux for the granted requester.
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_op  = '0;
      sel_rnd = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_a   = req_op_a[i*WIDTH +: WIDTH];
            sel_b   = req_op_b[i*WIDTH +: WIDTH];
            sel_op  = req_op_code[i*2 +: 2];
            sel_rnd = req_rnd[i];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: one operation in flight, response handshake returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (grant_found)      state_next = S_EXEC;
         S_EXEC:  if (cnt == '0)        state_next = S_RESP;
         S_RESP:  if (rsp_ready[owner]) state_next = S_IDLE;
         default:                       state_next = S_IDLE;
      endcase
   end

   // FSM outputs: grant pulse in IDLE (suppressed while in reset), response
   // valid to the owner in RESP, busy outside IDLE.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = rst_n && (state == S_IDLE) && grant_found && (grant_idx == PW'(i));
         rsp_valid[i] = (state == S_RESP) && (owner == PW'(i));
      end
      busy = (state != S_IDLE);
   end

   // Datapath: operand capture on grant, settle countdown, result capture and
   // sticky flag accumulation. A clear coincident with a capture keeps only
   // the flags of that capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         owner        <= '0;
         cnt          <= '0;
         alu_op_a     <= '0;
         alu_op_b     <= '0;
         alu_op_code  <= '0;
         alu_rnd      <= 1'b0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
         sticky_flags <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  alu_op_a    <= sel_a;
                  alu_op_b    <= sel_b;
                  alu_op_code <= sel_op;
                  alu_rnd     <= sel_rnd;
                  owner       <= grant_idx;
                  cnt         <= CNT_INIT;
                  rr_ptr      <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
               end
            end
            S_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_flags  <= alu_flags;
               end
            end
            default: ;
         endcase

         if (capture) begin
            sticky_flags <= sticky_clr ? alu_flags : (sticky_flags | alu_flags);
         end else if (sticky_clr) begin
            sticky_flags <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_req_sched
//  Description : Self-checking bench for alu_req_sched with a lookup-table
//                ALU stub, round-robin reference and response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_req_sched;

   localparam int NREQ   = 2;
   localparam int SETTLE = 2;
   localparam int WIDTH  = 32;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic        rnd;
   } op_t;

   typedef struct {
      int          owner;
      logic [31:0] res;
      logic [4:0]  flags;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_op_a;
   logic [NREQ*WIDTH-1:0] req_op_b;
   logic [NREQ*2-1:0]     req_op_code;
   logic [NREQ-1:0]       req_rnd;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]      rsp_result;
   logic [4:0]            rsp_flags;
   logic [WIDTH-1:0]      alu_op_a;
   logic [WIDTH-1:0]      alu_op_b;
   logic [1:0]            alu_op_code;
   logic                  alu_rnd;
   logic [WIDTH-1:0]      alu_result;
   logic [4:0]            alu_flags;
   logic [4:0]            sticky_flags;
   logic                  sticky_clr;
   logic                  busy;

   op_t         req_q[NREQ][$];
   exp_t        sb[$];
   int          grant_log[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          grant_cyc = 0;
   int          exp_rr = 0;
   logic [4:0]  exp_sticky = '0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_flags = '0;

   alu_req_sched #(.EXP(8), .FRAC(23), .WIDTH(WIDTH), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_code(req_op_code), .req_rnd(req_rnd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code), .alu_rnd(alu_rnd),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ALU stand-in: known IEEE single results for the directed cases, a
   // deterministic mix of the operands for everything else.
   function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op, input logic rnd);
      logic [36:0] r;
      r = {5'b00000, a ^ b ^ {29'b0, rnd, op}};
      if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) r = {5'b00000, 32'h40400000};
      if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) r = {5'b00000, 32'h40C00000};
      if (op == 2'b10 && a == 32'h3FC00000 && b == 32'h40000000) r = {5'b00000, 32'h40400000};
      if (op == 2'b11 && a == 32'h3F800000 && b == 32'h00000000) r = {5'b01000, 32'h7F800000};
      if (op == 2'b11 && a == 32'h3F800000 && b == 32'h40400000) r = {5'b00001, 32'h3EAAAAAB};
      return r;
   endfunction

   always_comb {alu_flags, alu_result} = alu_model(alu_op_a, alu_op_b, alu_op_code, alu_rnd);

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic rnd);
      op_t t;
      t.a = a; t.b = b; t.op = op; t.rnd = rnd;
      req_q[r].push_back(t);
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_req_ready"},    req_ready,    0);
      check_val({tag, "_rsp_valid"},    rsp_valid,    0);
      check_val({tag, "_rsp_result"},   rsp_result,   0);
      check_val({tag, "_rsp_flags"},    rsp_flags,    0);
      check_val({tag, "_alu_op_a"},     alu_op_a,     0);
      check_val({tag, "_alu_op_b"},     alu_op_b,     0);
      check_val({tag, "_alu_op_code"},  alu_op_code,  0);
      check_val({tag, "_alu_rnd"},      alu_rnd,      0);
      check_val({tag, "_sticky_flags"}, sticky_flags, 0);
      check_val({tag, "_busy"},         busy,         0);
   endtask

   function automatic int pending();
      int n;
      n = sb.size() + int'(busy);
      for (int i = 0; i < NREQ; i++) n += req_q[i].size();
      return n;
   endfunction

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while (pending() != 0 && k < max) begin
         @(negedge clk);
         k++;
      end
      if (k >= max) check_val("idle_timeout", pending(), 0);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 sticky_clr = 1'b1;
      @(posedge clk); #1 sticky_clr = 1'b0;
   endtask

   // Requester driver: present the head of each queue, hold until accepted.
   initial begin
      req_valid   = '0;
      req_op_a    = '0;
      req_op_b    = '0;
      req_op_code = '0;
      req_rnd     = '0;
      forever begin
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_q[i].size() > 0) begin
               req_valid[i]                = 1'b1;
               req_op_a[i*WIDTH +: WIDTH]  = req_q[i][0].a;
               req_op_b[i*WIDTH +: WIDTH]  = req_q[i][0].b;
               req_op_code[i*2 +: 2]       = req_q[i][0].op;
               req_rnd[i]                  = req_q[i][0].rnd;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: grant order, scoreboard of responses, latency and sticky model.
   initial begin
      int          g;
      logic [36:0] m;
      logic        prev_rv;
      logic        prev_clr;
      prev_rv  = 1'b0;
      prev_clr = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rv  = 1'b0;
            prev_clr = 1'b0;
         end else begin
            if (rsp_valid != 0 && !prev_rv && sb.size() > 0)
               exp_sticky = prev_clr ? sb[0].flags : (exp_sticky | sb[0].flags);
            else if (prev_clr)
               exp_sticky = '0;
            check_val("sticky", sticky_flags, exp_sticky);

            if (req_ready != 0) begin
               g = rr_pick(req_valid, exp_rr);
               check_val("grant", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
               check_val("ready_while_busy", busy, 0);
               if (g >= 0 && req_ready[g] && req_q[g].size() > 0) begin
                  m = alu_model(req_q[g][0].a, req_q[g][0].b, req_q[g][0].op, req_q[g][0].rnd);
                  sb.push_back('{owner: g, res: m[31:0], flags: m[36:32]});
                  grant_log.push_back(g);
                  exp_rr    = (g + 1) % NREQ;
                  grant_cyc = cyc;
                  void'(req_q[g].pop_front());
               end
            end

            if (rsp_valid != 0) begin
               if (sb.size() == 0) begin
                  check_val("rsp_unexpected", rsp_valid, 0);
               end else begin
                  check_val("rsp_owner",  rsp_valid,  64'd1 << sb[0].owner);
                  check_val("rsp_result", rsp_result, sb[0].res);
                  check_val("rsp_flags",  rsp_flags,  sb[0].flags);
                  if (!prev_rv) check_val("latency", cyc - grant_cyc, SETTLE + 1);
                  if (rsp_ready[sb[0].owner]) begin
                     last_res   = rsp_result;
                     last_flags = rsp_flags;
                     void'(sb.pop_front());
                  end
               end
            end
            prev_rv  = (rsp_valid != 0);
            prev_clr = sticky_clr;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Directed sequence.
   initial begin
      int k;
      rsp_ready  = '1;
      sticky_clr = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset("reset");
      #3 rst_n = 1'b1;

      // Single add on requester 0.
      push_op(0, 32'h3F800000, 32'h40000000, 2'b00, 1'b0);
      wait_idle(50);
      check_val("add_result", last_res, 32'h40400000);
      check_val("add_flags", last_flags, 0);
      check_val("add_grant", grant_log[0], 0);

      // One op on requester 1 brings the pointer back to requester 0.
      push_op(1, 32'h12345678, 32'h0F0F0F0F, 2'b01, 1'b1);
      wait_idle(50);

      // Both requesters contend continuously with mul: strict alternation.
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         push_op(0, 32'h40000000, 32'h40400000, 2'b10, 1'b0);
         push_op(1, 32'h3FC00000, 32'h40000000, 2'b10, 1'b1);
      end
      wait_idle(200);
      check_val("alt_count", grant_log.size(), 8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check_val($sformatf("alt_grant%0d", i), grant_log[i], i % 2);

      // Divide by zero on requester 1, then clear sticky.
      pulse_clr();
      push_op(1, 32'h3F800000, 32'h00000000, 2'b11, 1'b0);
      wait_idle(50);
      check_val("div0_result", last_res, 32'h7F800000);
      check_val("div0_flags", last_flags, 5'b01000);
      check_val("div0_sticky", sticky_flags, 5'b01000);
      pulse_clr();
      @(negedge clk);
      check_val("sticky_cleared", sticky_flags, 0);

      // Response back-pressure: only the non-owner bit of rsp_ready is high.
      rsp_ready = 2'b10;
      push_op(0, 32'h40000000, 32'h40400000, 2'b10, 1'b0);
      k = 0;
      while (rsp_valid == 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("stall_rsp", rsp_valid, 2'b01);
      push_op(1, 32'hCAFEF00D, 32'h01020304, 2'b00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("stall_valid", rsp_valid, 2'b01);
         check_val("stall_result", rsp_result, 32'h40C00000);
         check_val("stall_busy", busy, 1);
         check_val("stall_no_ready", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = '1;
      @(negedge clk);
      @(negedge clk);
      check_val("release_idle", busy, 0);
      check_val("release_grant", req_ready, 2'b10);
      wait_idle(50);

      // Random traffic with random response back-pressure.
      for (int i = 0; i < 6; i++) begin
         push_op(0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         push_op(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      k = 0;
      while (pending() != 0 && k < 400) begin
         @(posedge clk); #1 rsp_ready = NREQ'($urandom);
         k++;
      end
      rsp_ready = '1;
      if (k >= 400) check_val("random_timeout", pending(), 0);

      // Clear coincident with an inexact capture keeps only that capture's flags.
      push_op(0, 32'h3F800000, 32'h00000000, 2'b11, 1'b0);
      wait_idle(50);
      check_val("pre_coinc_sticky", sticky_flags, 5'b01000);
      push_op(0, 32'h3F800000, 32'h40400000, 2'b11, 1'b0);
      k = 0;
      while (req_ready[0] == 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("coinc_grant", req_ready, 2'b01);
      repeat (SETTLE) @(posedge clk);
      #1 sticky_clr = 1'b1;
      @(posedge clk); #1 sticky_clr = 1'b0;
      @(negedge clk);
      check_val("coinc_sticky", sticky_flags, 5'b00001);
      wait_idle(50);
      check_val("coinc_result", last_res, 32'h3EAAAAAB);

      // Asynchronous reset in the middle of EXEC.
      push_op(0, 32'h40000000, 32'h40400000, 2'b10, 1'b0);
      k = 0;
      while (req_ready[0] == 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      push_op(0, 32'h3FC00000, 32'h40000000, 2'b10, 1'b0);
      push_op(1, 32'h11111111, 32'h22222222, 2'b01, 1'b0);
      @(negedge clk);
      check_val("exec_busy", busy, 1);
      check_val("exec_no_rsp", rsp_valid, 0);
      #1 rst_n = 1'b0;
      #1 check_reset("rst_exec");
      sb.delete();
      grant_log.delete();
      exp_rr     = 0;
      exp_sticky = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      wait_idle(100);
      check_val("post_rst_count", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         check_val("post_rst_first", grant_log[0], 0);
         check_val("post_rst_second", grant_log[1], 1);
      end
      check_val("post_rst_result", last_res, 32'h11111111 ^ 32'h22222222 ^ 32'h1);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
